sc_stream_decoder: RTL and testbench

//  Stochastic-to-binary decoder: the receiving end of the SC bitstream interface.

---
 rtl/sc_stream_decoder_pkg.sv | 16 +
 rtl/sc_stream_decoder_if.sv | 24 ++
 rtl/sc_stream_decoder_popcount.sv | 35 +++
 rtl/sc_stream_decoder.sv | 102 ++++++++++
 tb/tb_sc_stream_decoder.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/sc_stream_decoder_pkg.sv
// Shared stochastic-computing definitions: default word/operand widths and the
// decoder's state encoding.
package sc_stream_decoder_pkg;

    localparam int SC_SEQ_W = 32;
    localparam int SC_NUM_W = 6;

    localparam logic ST_ACC  = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    typedef enum logic {
        STATE_ACC  = ST_ACC,
        STATE_HOLD = ST_HOLD
    } dec_state_t;

endpackage

// File: rtl/sc_stream_decoder_if.sv
// Input word stream and output result handshake of the stochastic-to-binary decoder.
interface sc_stream_decoder_if #(
    parameter int SEQ_W = 32,
    parameter int CNT_W = 8,
    parameter int NUM_W = 6
) ();
    logic             in_valid;
    logic             in_ready;
    logic [SEQ_W-1:0] seq_in;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] count_out;
    logic [NUM_W-1:0] num_out;

    modport master (
        output in_valid, seq_in, out_ready,
        input  in_ready, out_valid, count_out, num_out
    );

    modport slave (
        input  in_valid, seq_in, out_ready,
        output in_ready, out_valid, count_out, num_out
    );
endinterface

// File: rtl/sc_stream_decoder_popcount.sv
// Combinational ones-count of a sequence word, built as a balanced adder tree
// over a power-of-two number of leaves (unused leaves tied to zero).
module sc_popcount #(
    parameter  int SEQ_W = 32,
    localparam int OUT_W = $clog2(SEQ_W + 1)
) (
    input  logic [SEQ_W-1:0] bits,
    output logic [OUT_W-1:0] count
);
    localparam int LEAVES = 1 << $clog2(SEQ_W);

    logic [OUT_W-1:0] leaf [LEAVES];

    for (genvar gi = 0; gi < LEAVES; gi++) begin : g_leaf
        if (gi < SEQ_W) begin : g_bit
            assign leaf[gi] = OUT_W'(bits[gi]);
        end else begin : g_pad
            assign leaf[gi] = '0;
        end
    end

    // Partial sums never exceed SEQ_W, so OUT_W bits suffice at every level.
    always_comb begin : tree
        logic [OUT_W-1:0] node [LEAVES];
        for (int i = 0; i < LEAVES; i++) begin
            node[i] = leaf[i];
        end
        for (int w = LEAVES / 2; w >= 1; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                node[i] = node[2*i] + node[2*i+1];
            end
        end
        count = node[0];
    end
endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: sums the ones of WORDS sequence words and presents
// the raw count plus a rounded, saturated NUM_W-bit value until it is accepted.
module sc_stream_decoder
    import sc_stream_decoder_pkg::*;
#(
    parameter  int SEQ_W = SC_SEQ_W,
    parameter  int WORDS = 4,
    parameter  int NUM_W = SC_NUM_W,
    localparam int CNT_W = $clog2(SEQ_W * WORDS + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    sc_stream_decoder_if.slave bus
);
    localparam int PC_W   = $clog2(SEQ_W + 1);
    localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SH     = $clog2(SEQ_W * WORDS) - NUM_W;
    localparam int RND    = (1 << SH) >> 1;
    localparam logic [CNT_W:0] MAX_NUM = (CNT_W + 1)'(2 ** NUM_W - 1);

    dec_state_t        state_q, state_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [NUM_W-1:0]  num_q, num_d;

    logic [PC_W-1:0]   pc;
    logic [CNT_W-1:0]  sum;
    logic [CNT_W:0]    rnd;
    logic              accept;

    sc_popcount #(.SEQ_W(SEQ_W)) u_popcount (
        .bits  (bus.seq_in),
        .count (pc)
    );

    assign bus.in_ready  = (state_q == STATE_ACC) && !rst;
    assign accept        = bus.in_valid && bus.in_ready;
    assign sum           = acc_q + CNT_W'(pc);
    // Round half-up by adding half an LSB before the shift; SH=0 degenerates to a pass-through.
    assign rnd           = ({1'b0, sum} + (CNT_W + 1)'(RND)) >> SH;

    assign bus.out_valid = out_valid_q;
    assign bus.count_out = count_q;
    assign bus.num_out   = num_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        wcnt_d      = wcnt_q;
        out_valid_d = out_valid_q;
        count_d     = count_q;
        num_d       = num_q;
        case (state_q)
            STATE_ACC: begin
                if (clr) begin
                    acc_d  = '0;
                    wcnt_d = '0;
                end else if (accept) begin
                    if (wcnt_q == WCNT_W'(WORDS - 1)) begin
                        count_d     = sum;
                        num_d       = (rnd > MAX_NUM) ? NUM_W'(MAX_NUM) : rnd[NUM_W-1:0];
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        wcnt_d      = '0;
                        state_d     = STATE_HOLD;
                    end else begin
                        acc_d  = sum;
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end
            STATE_HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = STATE_ACC;
                end
            end
            default: state_d = STATE_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= STATE_ACC;
            acc_q       <= '0;
            wcnt_q      <= '0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
            num_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            wcnt_q      <= wcnt_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
            num_q       <= num_d;
        end
    end
endmodule

// File: tb/tb_sc_stream_decoder.sv
// Self-checking bench for sc_stream_decoder (SEQ_W=32, WORDS=4, NUM_W=6).
module tb_sc_stream_decoder;
    localparam int SEQ_W = 32;
    localparam int WORDS = 4;
    localparam int NUM_W = 6;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;

    int vec_cnt = 0;
    int err_cnt = 0;

    sc_stream_decoder_if #(.SEQ_W(SEQ_W), .CNT_W(CNT_W), .NUM_W(NUM_W)) bus ();

    sc_stream_decoder #(.SEQ_W(SEQ_W), .WORDS(WORDS), .NUM_W(NUM_W)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w [4];
        int          gap_max;
        int          exp_count;
        int          exp_num;
        string       name;
    } vec_t;

    vec_t vecs [3];

    task automatic check(input string name, input int act, input int exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: ones in the window, rounded halving, saturated to 6 bits.
    function automatic int model_count(input logic [31:0] w [4]);
        int c = 0;
        for (int i = 0; i < 4; i++) c += $countones(w[i]);
        return c;
    endfunction

    function automatic int model_num(input int c);
        int n = (c + 1) / 2;
        return (n > 63) ? 63 : n;
    endfunction

    task automatic send_word(input logic [31:0] w, input int gap, input string name);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.seq_in   = w;
        while (!bus.in_ready && t < 20) begin
            tick();
            t++;
        end
        if (t >= 20) check({name, "_accept_timeout"}, 0, 1);
        tick();
        bus.in_valid = 1'b0;
        bus.seq_in   = $urandom;
        for (int g = 0; g < gap; g++) tick();
    endtask

    task automatic take_result(input int exp_c, input int exp_n, input int hold, input string name);
        int t = 0;
        while (!bus.out_valid && t < 20) begin
            tick();
            t++;
        end
        check({name, "_out_valid"}, int'(bus.out_valid), 1);
        check({name, "_count"}, int'(bus.count_out), exp_c);
        check({name, "_num"}, int'(bus.num_out), exp_n);
        for (int h = 0; h < hold; h++) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({name, "_released"}, int'(bus.out_valid), 0);
    endtask

    // Sends a window; the result must be visible right after the last accepting edge.
    task automatic run_window(input logic [31:0] w [4], input int gap_max,
                              input int exp_c, input int exp_n, input int hold, input string name);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check({name, "_no_early_valid"}, int'(bus.out_valid), 0);
            send_word(w[i], (i == 3) ? 0 : ((gap_max > 0) ? $urandom_range(gap_max, 1) : 0), name);
            if (i == 3) check({name, "_latency"}, int'(bus.out_valid), 1);
        end
        take_result(exp_c, exp_n, hold, name);
    endtask

    initial begin
        logic [31:0] rw [4];
        int c0, n0;

        vecs[0] = '{w: '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
                    gap_max: 0, exp_count: 128, exp_num: 63, name: "all_ones"};
        vecs[1] = '{w: '{32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF},
                    gap_max: 0, exp_count: 64, exp_num: 32, name: "half_ones"};
        vecs[2] = '{w: '{32'h55555555, 32'h55555555, 32'h55555555, 32'h55555555},
                    gap_max: 3, exp_count: 64, exp_num: 32, name: "alt_gaps"};

        bus.in_valid  = 1'b0;
        bus.seq_in    = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        check("rst_in_ready", int'(bus.in_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_count", int'(bus.count_out), 0);
        check("rst_num", int'(bus.num_out), 0);
        check("rst_in_ready_released", int'(bus.in_ready), 1);

        for (int v = 0; v < 3; v++)
            run_window(vecs[v].w, vecs[v].gap_max, vecs[v].exp_count, vecs[v].exp_num, 0, vecs[v].name);

        // Hold the result for 10 cycles while offering words and pulsing clr.
        rw = '{32'h0F0F0F0F, 32'h00000007, 32'hFFFF0000, 32'h80000001};
        for (int i = 0; i < 4; i++) send_word(rw[i], 0, "hold");
        c0 = int'(bus.count_out);
        n0 = int'(bus.num_out);
        check("hold_count", c0, 16 + 3 + 16 + 2);
        check("hold_num", n0, 19);
        bus.in_valid = 1'b1;
        bus.seq_in   = 32'hFFFFFFFF;
        for (int h = 0; h < 10; h++) begin
            clr = (h == 4 || h == 5);
            tick();
            check("hold_valid_stable", int'(bus.out_valid), 1);
            check("hold_count_stable", int'(bus.count_out), c0);
            check("hold_num_stable", int'(bus.num_out), n0);
            check("hold_in_ready", int'(bus.in_ready), 0);
        end
        clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("hold_release_valid", int'(bus.out_valid), 0);
        check("hold_release_in_ready", int'(bus.in_ready), 1);

        // Two full words, then clr together with a valid word: both discarded.
        send_word(32'hFFFFFFFF, 0, "clr");
        send_word(32'hFFFFFFFF, 0, "clr");
        clr = 1'b1;
        bus.in_valid = 1'b1;
        bus.seq_in   = 32'hFFFFFFFF;
        tick();
        clr = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_no_valid", int'(bus.out_valid), 0);
        rw = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000000};
        run_window(rw, 0, 3, 2, 0, "clr_window");

        // Reset mid-window: no result for the aborted window.
        for (int i = 0; i < 3; i++) send_word(32'hFFFFFFFF, 0, "rst_mid");
        rst = 1'b1;
        #1;
        check("rst_mid_in_ready", int'(bus.in_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_no_valid", int'(bus.out_valid), 0);
        send_word(32'hFFFFFFFF, 0, "rst_mid");
        check("rst_mid_no_result", int'(bus.out_valid), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        rw = '{32'h0, 32'h0, 32'h0, 32'h0};
        run_window(rw, 0, 0, 0, 0, "rst_then_zero");

        // Randomized windows against the reference model.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(3, 0))
                    0: rw[i] = $urandom;
                    1: rw[i] = 32'hFFFFFFFF;
                    2: rw[i] = $urandom & $urandom;
                    default: rw[i] = $urandom | $urandom;
                endcase
            end
            c0 = model_count(rw);
            run_window(rw, $urandom_range(2, 0), c0, model_num(c0), $urandom_range(3, 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
